// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared widths, constants and queue entry type for the fetch front end
package ifetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [ADDR_W-1:0] WORD_INC = 32'd4;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] data;
    logic              filled;
  } entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - circular entry buffer with independent alloc, fill and pop pointers
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   alloc,
  input  logic [ADDR_W-1:0]      alloc_pc,
  input  logic                   fill,
  input  logic [INST_W-1:0]      fill_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] unfilled_cnt,
  output logic                   full
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  entry_t        mem [DEPTH];
  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] pop_ptr;

  // Pointers carry a wrap bit so differences give occupancy directly.
  // fill_ptr never passes alloc_ptr and pop_ptr never passes fill_ptr.
  assign count        = alloc_ptr - pop_ptr;
  assign unfilled_cnt = alloc_ptr - fill_ptr;
  assign full         = (count == PW'(DEPTH));
  assign head         = mem[pop_ptr[IW-1:0]];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      pop_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        mem[alloc_ptr[IW-1:0]] <= '{pc: alloc_pc, data: '0, filled: 1'b0};
        alloc_ptr <= alloc_ptr + PW'(1);
      end
      if (fill) begin
        mem[fill_ptr[IW-1:0]].data   <= fill_data;
        mem[fill_ptr[IW-1:0]].filled <= 1'b1;
        fill_ptr <= fill_ptr + PW'(1);
      end
      if (pop) pop_ptr <= pop_ptr + PW'(1);
    end
  end
endmodule

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - fetch PC owner, imem request gating, stale-response drop and redirect handling
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                DEPTH    = 4
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int DW = $clog2(DEPTH + 1) + 1;

  logic [ADDR_W-1:0] fpc;
  logic [DW-1:0]     drop_cnt;
  logic [DW-1:0]     drop_next;
  entry_t            head;
  logic [PW-1:0]     count;
  logic [PW-1:0]     unfilled_cnt;
  logic              full;
  logic              req_fire;
  logic              rsp_fill;
  logic              inst_fire;

  assign imem_req_valid = !reset && !redirect_valid && !full;
  assign imem_req_addr  = fpc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // count guards against a popped head whose filled bit is still set.
  assign inst_valid = !reset && (count != '0) && head.filled;
  assign inst_fire  = inst_valid && inst_ready;
  assign inst       = inst_valid ? head.data : '0;
  assign inst_pc    = inst_valid ? head.pc : '0;

  assign rsp_fill = imem_rsp_valid && !redirect_valid && (drop_cnt == '0) && (unfilled_cnt != '0);

  // Every outstanding request becomes stale on redirect; a response arriving
  // in the redirect cycle retires one of them immediately.
  always_comb begin
    drop_next = drop_cnt + DW'(unfilled_cnt);
    if (imem_rsp_valid && (drop_next != '0)) drop_next = drop_next - DW'(1);
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .flush        (redirect_valid),
    .alloc        (req_fire),
    .alloc_pc     (fpc),
    .fill         (rsp_fill),
    .fill_data    (imem_rsp_data),
    .pop          (inst_fire),
    .head         (head),
    .count        (count),
    .unfilled_cnt (unfilled_cnt),
    .full         (full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      fpc      <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      fpc      <= redirect_pc & ~ADDR_W'(3);
      drop_cnt <= drop_next;
    end else begin
      if (req_fire) fpc <= fpc + WORD_INC;
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - DW'(1);
    end
  end

  rsp_has_target: assert property (@(posedge clock) disable iff (reset)
    imem_rsp_valid |-> ((drop_cnt != '0) || (unfilled_cnt != '0)));
endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - randomized scoreboard bench for the instruction fetch queue
module tb_ifetch_queue;
  localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  ifetch_queue #(.RESET_PC(32'h0000_3000), .DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lat_min = 1, lat_max = 1;
  int req_rdy_pct = 100, inst_rdy_pct = 100, redir_pct = 0;
  int force_redir = 0;
  logic [31:0] force_redir_pc = '0;
  logic rst_req = 1'b1;
  int n_accept = 0, n_pop = 0, epoch = 0, last_due = 0;
  logic rsp_stale = 1'b0;

  // imem model: in-order pending responses tagged with the fetch epoch that issued them
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          pend_epoch[$];
  // expected instruction stream, in delivery order
  logic [31:0] sb_pc[$];
  logic [31:0] exp_req_addr = 32'h3000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver + imem model: inputs change at negedge, handshakes are evaluated at +2
  always @(negedge clock) begin
    int stale;
    int lat;
    cyc++;
    reset = rst_req;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    rsp_stale      = 1'b0;
    if (reset) begin
      pend_addr.delete();
      pend_due.delete();
      pend_epoch.delete();
      last_due = 0;
    end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend_addr[0] ^ XOR_KEY;
      rsp_stale      = (pend_epoch[0] != epoch);
      pend_addr.delete(0);
      pend_due.delete(0);
      pend_epoch.delete(0);
    end
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (!reset && force_redir > 0) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_redir_pc;
      force_redir--;
    end else if (!reset && $urandom_range(99) < redir_pct) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3000 + 32'($urandom_range(4095));
    end
    imem_req_ready = ($urandom_range(99) < req_rdy_pct);
    inst_ready     = ($urandom_range(99) < inst_rdy_pct);
    #2;
    if (reset) begin
      check("rst_req_valid", 32'(imem_req_valid), 0);
      check("rst_inst_valid", 32'(inst_valid), 0);
      check("rst_inst", inst, 0);
      check("rst_inst_pc", inst_pc, 0);
      sb_pc.delete();
      exp_req_addr = 32'h3000;
      n_accept = 0;
      n_pop = 0;
    end else begin
      stale = int'(rsp_stale);
      foreach (pend_epoch[i]) if (pend_epoch[i] != epoch) stale++;
      check("drop_cnt", 32'(dut.drop_cnt), 32'(stale));
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_req_addr);
        lat = $urandom_range(lat_max, lat_min);
        last_due = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(last_due);
        pend_epoch.push_back(epoch);
        sb_pc.push_back(exp_req_addr);
        exp_req_addr = exp_req_addr + 32'd4;
        n_accept++;
      end
      if (redirect_valid) begin
        check("req_valid_on_redirect", 32'(imem_req_valid), 0);
        sb_pc.delete();
        epoch++;
        exp_req_addr = redirect_pc & ~32'd3;
      end
    end
  end

  // monitor: every delivered instruction is compared against the scoreboard head
  always @(negedge clock) begin
    #1;
    if (!reset && inst_valid && inst_ready) begin
      n_pop++;
      if (sb_pc.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_unexpected: got pc %h, expected no instruction (cycle %0d)", inst_pc, cyc);
      end else begin
        check("inst_pc", inst_pc, sb_pc[0]);
        check("inst_data", inst, sb_pc[0] ^ XOR_KEY);
        sb_pc.delete(0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clock);
      #3;
    end
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    step(2);
    rst_req = 1'b0;
  endtask

  initial begin
    int found;
    int pops_before;

    do_reset();
    step(12);
    check("t1_accepts", n_accept, 12);
    check("t1_pops", n_pop, 10);

    inst_rdy_pct = 0;
    do_reset();
    step(10);
    check("t2_accepts_full", n_accept, 4);
    check("t2_req_valid_full", 32'(imem_req_valid), 0);
    inst_rdy_pct = 100;
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      step(1);
      if (imem_req_valid) found = 1;
    end
    check("t2_resume_found", found, 1);
    check("t2_resume_addr", imem_req_addr, 32'h3010);
    step(8);
    check("t2_pops", 32'(n_pop >= 4), 1);

    lat_min = 3; lat_max = 3;
    do_reset();
    step(2);
    req_rdy_pct = 0;
    force_redir = 1;
    force_redir_pc = 32'h3100;
    step(1);
    req_rdy_pct = 100;
    step(1);
    check("t3_drop_2", 32'(dut.drop_cnt), 2);
    step(1);
    check("t3_drop_1", 32'(dut.drop_cnt), 1);
    step(1);
    check("t3_drop_0", 32'(dut.drop_cnt), 0);
    step(8);
    check("t3_pops", 32'(n_pop > 0), 1);

    lat_min = 2; lat_max = 2;
    do_reset();
    step(8);
    pops_before = n_pop;
    force_redir = 1;
    force_redir_pc = 32'h3200;
    step(1);
    check("t4_pop_in_redirect", 32'(inst_valid && inst_ready), 1);
    check("t4_rsp_in_redirect", 32'(imem_rsp_valid), 1);
    check("t4_popped", n_pop, pops_before + 1);
    step(1);
    check("t4_drop_after", 32'(dut.drop_cnt), 1);
    lat_min = 3; lat_max = 3;
    force_redir = 2;
    force_redir_pc = 32'h3300;
    step(8);

    lat_min = 1; lat_max = 1;
    force_redir = 1;
    force_redir_pc = 32'hFFFF_FFFE;
    step(1);
    step(1);
    check("t5_req_valid", 32'(imem_req_valid), 1);
    check("t5_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    step(1);
    check("t5_addr_wrap", imem_req_addr, 32'h0000_0000);
    step(8);

    inst_rdy_pct = 0;
    lat_min = 3; lat_max = 3;
    do_reset();
    step(4);
    check("t6_accepts", n_accept, 4);
    rst_req = 1'b1;
    step(1);
    rst_req = 1'b0;
    step(1);
    check("t6_inst_valid", 32'(inst_valid), 0);
    check("t6_req_valid", 32'(imem_req_valid), 1);
    check("t6_req_addr", imem_req_addr, 32'h3000);
    check("t6_drop", 32'(dut.drop_cnt), 0);

    inst_rdy_pct = 100;
    do_reset();
    for (int blk = 0; blk < 20; blk++) begin
      lat_min      = $urandom_range(3, 1);
      lat_max      = lat_min + $urandom_range(2);
      req_rdy_pct  = $urandom_range(100, 40);
      inst_rdy_pct = $urandom_range(100, 30);
      redir_pct    = $urandom_range(8);
      if (blk % 7 == 6) do_reset();
      step(100);
    end
    redir_pct = 0;
    req_rdy_pct = 100;
    inst_rdy_pct = 100;
    step(30);
    check("rand_pops", 32'(n_pop > 0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
